// File: rtl/serial_word_packer_pkg.sv
// serial_word_packer_pkg: shared width and lane-placement helpers for the word packer
package serial_word_packer_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lane_off(input int k, input bit msb_first, input int ratio, input int in_w);
    return msb_first ? (ratio - 1 - k) * in_w : k * in_w;
  endfunction
  localparam int DEF_RATIO = 4;
  localparam int LANES_W = clog2(DEF_RATIO + 1);
endpackage

// File: rtl/packer_out_stage.sv
// packer_out_stage: output word register with valid/ready hold; parity lanes under PACKER_PARITY_EN
module packer_out_stage
  import serial_word_packer_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = DEF_RATIO,
  parameter int MSB_FIRST = 1,
  parameter int LW        = LANES_W
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic                  load,
  input  logic [IN_W*RATIO-1:0] word,
  input  logic [LW-1:0]         lanes,
  input  logic                  ready_out,
  output logic                  valid_out,
  output logic [IN_W*RATIO-1:0] Data_out,
  output logic [LW-1:0]         lanes_out
`ifdef PACKER_PARITY_EN
  ,
  output logic [RATIO-1:0]      parity_out
`endif
);
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) begin
      valid_out <= 1'b0;
      Data_out  <= '0;
      lanes_out <= '0;
    end else begin
      valid_out <= load || (valid_out && !ready_out);
      if (load) begin
        Data_out  <= word;
        lanes_out <= lanes;
      end
    end
`ifdef PACKER_PARITY_EN
  logic [RATIO-1:0] par;
  always_comb begin
    par = '0;
    for (int k = 0; k < RATIO; k++) par[k] = ^word[lane_off(k, MSB_FIRST != 0, RATIO, IN_W) +: IN_W];
  end
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) parity_out <= '0;
    else if (load) parity_out <= par;
`endif
endmodule

// File: rtl/serial_word_packer.sv
// serial_word_packer: packs RATIO IN_W-bit symbols into one word with flush and backpressure
// Optional per-lane even parity output enabled by PACKER_PARITY_EN.
module serial_word_packer
  import serial_word_packer_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = DEF_RATIO,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk_4f,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [IN_W-1:0]              Data_in,
  input  logic                         flush_in,
  output logic                         ready_in,
  input  logic                         ready_out,
  output logic                         valid_out,
  output logic [IN_W*RATIO-1:0]        Data_out,
  output logic [clog2(RATIO+1)-1:0]    lanes_out
`ifdef PACKER_PARITY_EN
  ,
  output logic [RATIO-1:0]             parity_out
`endif
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW = clog2(RATIO);
  localparam int LW = clog2(RATIO + 1);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  logic [OUT_W-1:0] acc, merged;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lanes;
  logic take, last, done;
  assign last = cnt == LAST;
  // Only the word-closing symbol or flush needs the output register free.
  assign ready_in = !(valid_out && !ready_out) || (!last && !flush_in);
  assign take = valid_in && ready_in;
  assign done = (take && last) || (flush_in && ready_in && (take || cnt != '0));
  assign lanes = LW'(cnt) + LW'(take);
  always_comb begin
    merged = acc;
    for (int k = 0; k < RATIO; k++)
      if (take && cnt == CW'(k)) merged[lane_off(k, MSB_FIRST != 0, RATIO, IN_W) +: IN_W] = Data_in;
  end
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (done) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= merged;
      cnt <= cnt + 1'b1;
    end
  packer_out_stage #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(MSB_FIRST), .LW(LW)) u_out (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .load      (done),
    .word      (merged),
    .lanes     (lanes),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .Data_out  (Data_out),
    .lanes_out (lanes_out)
`ifdef PACKER_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );
endmodule

// File: tb/tb_serial_word_packer.sv
// tb_serial_word_packer: scoreboard bench driving MSB-first and LSB-first packers in lockstep
module tb_serial_word_packer;
  logic clk_4f = 1'b0;
  logic reset = 1'b0;
  logic valid_in = 1'b0;
  logic [7:0] Data_in = '0;
  logic flush_in = 1'b0;
  logic ready_out = 1'b1;
  logic ready_in, valid_out, ready_in_l, valid_out_l;
  logic [31:0] Data_out, Data_out_l;
  logic [2:0] lanes_out, lanes_out_l;
  logic [3:0] parity_out, parity_out_l;
  int checks = 0;
  int failures = 0;
  int stalls = 0;

  typedef struct {
    logic [31:0] dm;
    logic [31:0] dl;
    logic [2:0]  ln;
    logic [3:0]  par;
  } exp_t;
  exp_t q[$];

  always #5 clk_4f = ~clk_4f;

  serial_word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) dut (
    .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .Data_in(Data_in), .flush_in(flush_in),
    .ready_in(ready_in), .ready_out(ready_out), .valid_out(valid_out), .Data_out(Data_out),
    .lanes_out(lanes_out)
`ifdef PACKER_PARITY_EN
    , .parity_out(parity_out)
`endif
  );

  serial_word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) dut_l (
    .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .Data_in(Data_in), .flush_in(flush_in),
    .ready_in(ready_in_l), .ready_out(ready_out), .valid_out(valid_out_l), .Data_out(Data_out_l),
    .lanes_out(lanes_out_l)
`ifdef PACKER_PARITY_EN
    , .parity_out(parity_out_l)
`endif
  );

`ifndef PACKER_PARITY_EN
  assign parity_out = '0;
  assign parity_out_l = '0;
`endif

  function automatic logic [3:0] par_of(input logic [31:0] w);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = ^w[31-8*k -: 8];
    return p;
  endfunction

  task automatic push(input logic [31:0] dm, input logic [31:0] dl, input logic [2:0] ln);
    exp_t e;
    e.dm = dm; e.dl = dl; e.ln = ln; e.par = par_of(dm);
    q.push_back(e);
  endtask

  task automatic push_p(input logic [31:0] dm, input logic [31:0] dl, input logic [2:0] ln, input logic [3:0] p);
    exp_t e;
    e.dm = dm; e.dl = dl; e.ln = ln; e.par = p;
    q.push_back(e);
  endtask

  // Each word handed over (valid_out && ready_out at the next edge) must match the queue head.
  always @(negedge clk_4f) begin
    exp_t e;
    if (reset && valid_out && ready_out) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got=%h lanes=%0d required=none", Data_out, lanes_out);
      end else begin
        e = q.pop_front();
        if (Data_out !== e.dm || lanes_out !== e.ln) begin
          failures++;
          $display("FAIL word_msb got=%h/%0d required=%h/%0d", Data_out, lanes_out, e.dm, e.ln);
        end
        checks++;
        if (valid_out_l !== 1'b1 || Data_out_l !== e.dl || lanes_out_l !== e.ln) begin
          failures++;
          $display("FAIL word_lsb got=%b/%h/%0d required=1/%h/%0d", valid_out_l, Data_out_l, lanes_out_l, e.dl, e.ln);
        end
`ifdef PACKER_PARITY_EN
        checks++;
        if (parity_out !== e.par || parity_out_l !== e.par) begin
          failures++;
          $display("FAIL parity got=%b/%b required=%b", parity_out, parity_out_l, e.par);
        end
`endif
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic v, input logic f);
    int n;
    valid_in = v; Data_in = d; flush_in = f;
    #1;
    n = 0;
    while (!ready_in && n < 100) begin
      @(posedge clk_4f); #1;
      n++;
      stalls++;
    end
    checks++;
    if (ready_in !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout ready_in=%b required=1", ready_in);
    end
    @(posedge clk_4f); #1;
    valid_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk_4f); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (valid_out !== 1'b0 || Data_out !== 32'h0 || lanes_out !== 3'd0 || ready_in !== 1'b1 || parity_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_state got=%b/%h/%0d/%b/%b required=0/0/0/1/0", valid_out, Data_out, lanes_out, ready_in, parity_out);
    end
    @(negedge clk_4f) reset = 1'b1;
    @(posedge clk_4f); #1;
  endtask

  task automatic test_basic();
    push(32'h01020304, 32'h04030201, 3'd4);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency valid_out=%b required=1", valid_out);
    end
    @(posedge clk_4f); #1;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle valid_out=%b required=0", valid_out);
    end
    drain();
  endtask

  task automatic test_flush();
    push(32'hAABB0000, 32'h0000BBAA, 3'd2);
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    drain();
    send(8'h00, 1'b0, 1'b1);
    @(posedge clk_4f); #1;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL empty_flush valid_out=%b required=0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[8];
    time t0;
    int s0;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    push({b[0], b[1], b[2], b[3]}, {b[3], b[2], b[1], b[0]}, 3'd4);
    push({b[4], b[5], b[6], b[7]}, {b[7], b[6], b[5], b[4]}, 3'd4);
    t0 = $time;
    s0 = stalls;
    for (int i = 0; i < 8; i++) send(b[i], 1'b1, 1'b0);
    checks++;
    if (stalls != s0 || $time - t0 != 80) begin
      failures++;
      $display("FAIL throughput stalls=%0d time=%0t required=0/80", stalls - s0, $time - t0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int s0;
    ready_out = 1'b0;
    push(32'h11223344, 32'h44332211, 3'd4);
    push(32'h55667788, 32'h88776655, 3'd4);
    send(8'h11, 1'b1, 1'b0); send(8'h22, 1'b1, 1'b0);
    send(8'h33, 1'b1, 1'b0); send(8'h44, 1'b1, 1'b0);
    s0 = stalls;
    send(8'h55, 1'b1, 1'b0); send(8'h66, 1'b1, 1'b0); send(8'h77, 1'b1, 1'b0);
    checks++;
    if (stalls != s0) begin
      failures++;
      $display("FAIL busy_accept stalls=%0d required=0", stalls - s0);
    end
    valid_in = 1'b1; Data_in = 8'h88;
    #1;
    checks++;
    if (ready_in !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready ready_in=%b required=0", ready_in);
    end
    repeat (3) @(posedge clk_4f);
    #1;
    checks++;
    if (ready_in !== 1'b0 || valid_out !== 1'b1 || Data_out !== 32'h11223344 || lanes_out !== 3'd4) begin
      failures++;
      $display("FAIL hold got=%b/%b/%h/%0d required=0/1/11223344/4", ready_in, valid_out, Data_out, lanes_out);
    end
    ready_out = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b1) begin
      failures++;
      $display("FAIL release_ready ready_in=%b required=1", ready_in);
    end
    @(posedge clk_4f); #1;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || Data_out !== 32'h55667788) begin
      failures++;
      $display("FAIL replace got=%b/%h required=1/55667788", valid_out, Data_out);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    ready_out = 1'b0;
    send(8'hC0, 1'b1, 1'b0); send(8'hFF, 1'b1, 1'b0);
    send(8'hEE, 1'b1, 1'b0); send(8'h11, 1'b1, 1'b0);
    send(8'h12, 1'b1, 1'b0); send(8'h34, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || Data_out !== 32'h0 || lanes_out !== 3'd0 || ready_in !== 1'b1 || parity_out !== 4'h0 || Data_out_l !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got=%b/%h/%0d/%b/%b required=0/0/0/1/0", valid_out, Data_out, lanes_out, ready_in, parity_out);
    end
    @(negedge clk_4f);
    reset = 1'b1;
    ready_out = 1'b1;
    @(posedge clk_4f); #1;
    push(32'hDEADBEEF, 32'hEFBEADDE, 3'd4);
    send(8'hDE, 1'b1, 1'b0); send(8'hAD, 1'b1, 1'b0);
    send(8'hBE, 1'b1, 1'b0); send(8'hEF, 1'b1, 1'b0);
    drain();
  endtask

`ifdef PACKER_PARITY_EN
  task automatic test_parity();
    push_p(32'h01030700, 32'h00070301, 3'd4, 4'b0101);
    push_p(32'h01000000, 32'h00000001, 3'd1, 4'b0001);
    send(8'h01, 1'b1, 1'b0); send(8'h03, 1'b1, 1'b0);
    send(8'h07, 1'b1, 1'b0); send(8'h00, 1'b1, 1'b0);
    checks++;
    if (parity_out !== 4'b0101) begin
      failures++;
      $display("FAIL parity_full got=%b required=0101", parity_out);
    end
    send(8'h01, 1'b1, 1'b1);
    checks++;
    if (parity_out !== 4'b0001) begin
      failures++;
      $display("FAIL parity_flush got=%b required=0001", parity_out);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef PACKER_PARITY_EN
    test_parity();
`endif
    repeat (3) @(posedge clk_4f);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Parametrised narrow-to-wide word packer, clocked on the fast lane clock `clk_4f`. It gathers RATIO consecutive IN_W-bit symbols into one OUT_W = IN_W*RATIO word. Compared with the fixed 8-to-32 converter, it adds:
- selectable lane order;
- partial-word flush with a lane count;
- ready/valid backpressure on both sides.

It sits between the byte-serial receive path and the 32-bit word consumers.

## Interface
- IN_W, 8, symbol width in bits (≥1).
- RATIO, 4, symbols per word (≥2); OUT_W = IN_W*RATIO.
- MSB_FIRST, 1, 1: first symbol lands in the most significant lane; 0: first symbol lands in the least significant lane.
- clk_4f  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  Data_in is valid this cycle.
- Data_in  in  IN_W  input symbol.
- flush_in  in  1  close the current word after this cycle's symbol, if any.
- ready_in  out  1  packer accepts valid_in/flush_in this cycle (combinational).
- ready_out  in  1  downstream accepts the word this cycle.
- valid_out  out  1  Data_out holds a word.
- Data_out  out  OUT_W  packed word; unused lanes are 0.
- lanes_out  out  clog2(RATIO+1)  number of valid lanes in Data_out (1..RATIO).
- parity_out  out  RATIO  per-lane even parity (only with PACKER_PARITY_EN).

## Operation
- State:
  - accumulator acc[OUT_W];
  - lane counter cnt, 0..RATIO-1;
  - output register holding valid_out, Data_out, lanes_out and parity_out.
- Definitions:
  - out_busy = valid_out && !ready_out.
  - ready_in = !out_busy || (cnt < RATIO-1 && !flush_in).
- Accept: valid_in && ready_in.
  - Data_in is written to lane cnt.
  - With MSB_FIRST=1, lane k occupies bits [OUT_W-1-k*IN_W -: IN_W]; otherwise bits [k*IN_W +: IN_W].
- Completion: any of the following.
  - An accept with cnt==RATIO-1.
  - flush_in && ready_in with an accept; lanes = cnt+1.
  - flush_in && ready_in with no accept and cnt>0; lanes = cnt.
- flush_in with no accept and cnt==0 is a no-op; no empty words are ever emitted.
- On completion, in the same edge:
  - load the output register from acc merged with the current symbol; lanes not yet written are 0;
  - set valid_out=1 and lanes_out to the lane count;
  - clear acc to 0 and set cnt=0.
- Otherwise an accept increments cnt.
- valid_out clears on ready_out, unless a completion reloads the register in the same cycle.
- While out_busy, Data_out, lanes_out and parity_out are held stable.
- Asserting reset at any time discards the partial word and any held output word.

## Timing
- Reset values:
  - valid_out=0, Data_out=0, lanes_out=0, parity_out=0;
  - acc=0, cnt=0;
  - ready_in=1.
- Latency: valid_out rises one cycle after the completing accept or flush.
- Throughput: one word per RATIO cycles with continuous valid_in and ready_out=1, with no bubbles.
- Completion and drain in the same cycle: the new word replaces the drained one and valid_out stays 1.
- Backpressure:
  - Non-completing symbols keep being accepted while out_busy.
  - The completing symbol or flush stalls (ready_in=0) until ready_out=1.
  - Upstream holds valid_in, Data_in and flush_in while ready_in=0.
- ready_in depends combinationally on ready_out and flush_in only; it has no path from valid_in.

## Configuration
- PACKER_PARITY_EN defined:
  - the parity_out port exists;
  - bit k is the XOR of lane k, computed at completion and registered with Data_out;
  - unused lanes give 0.
- PACKER_PARITY_EN undefined: the parity_out port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package serial_word_packer_pkg contains:
  - the clog2 function;
  - the lane bit-offset function, with MSB_FIRST and RATIO as arguments;
  - the lane-count width constant.
- Sub-module packer_out_stage: the output register plus the valid/ready hold logic, including the parity registers when enabled. The top level holds acc, cnt, the completion decode and ready_in.

## Test plan
- Defaults (IN_W=8, RATIO=4, MSB_FIRST=1) and ready_out=1:
  - Symbols 0x01,0x02,0x03,0x04 on consecutive cycles -> next cycle valid_out=1, Data_out=0x01020304, lanes_out=4, for exactly one cycle.
- MSB_FIRST=0:
  - Same stimulus -> Data_out=0x04030201, lanes_out=4.
- Partial-word flush:
  - 0xAA, 0xBB, then flush_in alone -> Data_out=0xAABB0000, lanes_out=2.
  - A further flush_in with cnt=0 -> no valid_out.
- Backpressure:
  - ready_out=0 with 0x11223344 held.
  - Send 0x55,0x66,0x77 -> all three accepted.
  - 0x88 -> ready_in=0 and Data_out is stable.
  - Raise ready_out -> 0x88 accepted; one cycle later Data_out=0x55667788.
- Reset mid-word:
  - reset=0 after 0x12,0x34 -> all outputs 0.
  - After release, 0xDE,0xAD,0xBE,0xEF -> Data_out=0xDEADBEEF, with no residue of the discarded bytes.
- PACKER_PARITY_EN:
  - 0x01,0x03,0x07,0x00 -> parity_out=4'b0101.
  - 0x01 then flush -> parity_out=4'b0001.
